// File: rtl/ccm_pkg.sv
// rtl/ccm_pkg.sv - shared widths, coefficient shifts and helpers for the x122 CCM arbiter
package ccm_pkg;

  localparam int CCM_STAGE_DEF = 4;

  // 122 = 2^7 - 2^2 - 2^1
  localparam int CCM_SH_A = 7;
  localparam int CCM_SH_B = 2;
  localparam int CCM_SH_C = 1;

  function automatic int ccm_wl(input int stage);
    return 2 * stage;
  endfunction

  function automatic int ccm_ow(input int stage);
    return 2 * (stage + 8);
  endfunction

  function automatic int ccm_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/ccm_rr_pick.sv
// rtl/ccm_rr_pick.sv - combinational rotate-priority picker starting at ptr_i
module ccm_rr_pick
  import ccm_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = ccm_clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   winner_o,
  output logic            any_o
);

  always_comb begin
    int          idx;
    logic [IW-1:0] sel;
    logic        found;
    idx      = 0;
    sel      = '0;
    found    = 1'b0;
    gnt_o    = '0;
    winner_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_i) + k) % NREQ;
      sel = IW'(idx);
      if (!found && req_i[sel]) begin
        found      = 1'b1;
        winner_o   = sel;
        gnt_o[sel] = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/online_ccm_122.sv
// rtl/online_ccm_122.sv - x122 constant multiplier on signed-digit operands, digit j = {plus, minus} at [2j+1:2j]
module online_ccm_122
  import ccm_pkg::*;
#(
  parameter  int STAGE = CCM_STAGE_DEF,
  localparam int WL    = ccm_wl(STAGE),
  localparam int OW    = ccm_ow(STAGE),
  localparam int HW    = OW / 2
) (
  input  logic [WL-1:0] x_i,
  output logic [OW-1:0] p_o
);

  logic [STAGE-1:0] xp, xn;
  logic [HW-1:0]    pos, neg;

  always_comb begin
    xp = '0;
    xn = '0;
    for (int j = 0; j < STAGE; j++) begin
      xp[j] = x_i[2*j+1];
      xn[j] = x_i[2*j];
    end
    // Result stays redundant: plus and minus halves are never subtracted
    pos = (HW'(xp) << CCM_SH_A) + (HW'(xn) << CCM_SH_B) + (HW'(xn) << CCM_SH_C);
    neg = (HW'(xn) << CCM_SH_A) + (HW'(xp) << CCM_SH_B) + (HW'(xp) << CCM_SH_C);
    p_o = '0;
    for (int j = 0; j < HW; j++) begin
      p_o[2*j+1] = pos[j];
      p_o[2*j]   = neg[j];
    end
  end

endmodule

// File: rtl/ccm_share_arb.sv
// rtl/ccm_share_arb.sv - round-robin sharing of one x122 CCM among NREQ requesters; CCM_ARB_STATS_EN adds grant counters
module ccm_share_arb
  import ccm_pkg::*;
#(
  parameter  int STAGE = CCM_STAGE_DEF,
  parameter  int NREQ  = 4,
  parameter  int LAT   = 2,
  localparam int WL    = ccm_wl(STAGE),
  localparam int OW    = ccm_ow(STAGE),
  localparam int IW    = ccm_clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*WL-1:0] req_data,
  output logic [NREQ-1:0]  gnt,
  output logic             resp_valid,
  output logic [IW-1:0]    resp_id,
  output logic [OW-1:0]    resp_data
`ifdef CCM_ARB_STATS_EN
  ,
  output logic [31:0]      stat_busy,
  output logic [NREQ*16-1:0] stat_gnt
`endif
);

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   winner;
  logic            pick_any;
  logic            take;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [WL-1:0]   op_q;
  logic [IW-1:0]   id_q;
  logic            v1_q;
  logic [OW-1:0]   prod;
  logic [OW-1:0]   rd_q  [LAT-1];
  logic [IW-1:0]   rid_q [LAT-1];
  logic [LAT-2:0]  rv_q;

  ccm_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .gnt_o    (pick_gnt),
    .winner_o (winner),
    .any_o    (pick_any)
  );

  online_ccm_122 #(.STAGE(STAGE)) u_ccm (
    .x_i (op_q),
    .p_o (prod)
  );

  always_comb begin
    take  = rst_n && !flush && pick_any;
    gnt   = take ? pick_gnt : '0;
    ptr_d = ptr_q;
    if (take) ptr_d = (winner == IW'(NREQ-1)) ? '0 : winner + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      op_q  <= '0;
      id_q  <= '0;
      v1_q  <= 1'b0;
      rv_q  <= '0;
      for (int i = 0; i < LAT-1; i++) begin
        rd_q[i]  <= '0;
        rid_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      v1_q  <= take;
      if (take) begin
        op_q <= req_data[winner*WL +: WL];
        id_q <= winner;
      end
      // Data only moves with a valid tag so resp_data holds between products
      rv_q[0] <= v1_q && !flush;
      if (v1_q) begin
        rd_q[0]  <= prod;
        rid_q[0] <= id_q;
      end
      for (int i = 1; i < LAT-1; i++) begin
        rv_q[i] <= rv_q[i-1] && !flush;
        if (rv_q[i-1]) begin
          rd_q[i]  <= rd_q[i-1];
          rid_q[i] <= rid_q[i-1];
        end
      end
    end
  end

  assign resp_valid = rst_n && rv_q[LAT-2];
  assign resp_id    = rst_n ? rid_q[LAT-2] : '0;
  assign resp_data  = rst_n ? rd_q[LAT-2] : '0;

`ifdef CCM_ARB_STATS_EN
  logic [31:0] busy_q;
  logic [15:0] cnt_q [NREQ];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      busy_q <= '0;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      if (take && busy_q != '1) busy_q <= busy_q + 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    stat_busy = busy_q;
    stat_gnt  = '0;
    for (int i = 0; i < NREQ; i++) stat_gnt[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_ccm_share_arb.sv
// tb/tb_ccm_share_arb.sv - scoreboard bench for ccm_share_arb (CCM_ARB_STATS_EN enables stats checks)
module tb_ccm_share_arb;

  localparam int STAGE = 4;
  localparam int NREQ  = 4;
  localparam int LAT   = 2;
  localparam int WL    = 2 * STAGE;
  localparam int OW    = 2 * (STAGE + 8);
  localparam int IW    = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*WL-1:0] req_data = '0;
  logic [NREQ-1:0]   gnt;
  logic              resp_valid;
  logic [IW-1:0]     resp_id;
  logic [OW-1:0]     resp_data;
`ifdef CCM_ARB_STATS_EN
  logic [31:0]       stat_busy;
  logic [NREQ*16-1:0] stat_gnt;
`endif

  always #5 clk = ~clk;

  ccm_share_arb #(.STAGE(STAGE), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data)
`ifdef CCM_ARB_STATS_EN
    ,
    .stat_busy  (stat_busy),
    .stat_gnt   (stat_gnt)
`endif
  );

  typedef struct {
    int            id;
    logic [OW-1:0] data;
    int            due;
  } exp_t;

  exp_t            exp_q[$];
  int              errors = 0;
  int              checks = 0;
  int              cyc = 0;
  int              mptr = 0;
  logic [NREQ-1:0] exp_gnt = '0;

  // Product as separate plus/minus magnitudes: 122*(P-N) = (128P+6N) - (128N+6P)
  function automatic logic [OW-1:0] ccm_model(input logic [WL-1:0] op);
    int p, n, pos, neg;
    logic [OW-1:0] r;
    p = 0;
    n = 0;
    for (int j = 0; j < STAGE; j++) begin
      p = p + (op[2*j+1] ? (1 << j) : 0);
      n = n + (op[2*j]   ? (1 << j) : 0);
    end
    pos = 128 * p + 6 * n;
    neg = 128 * n + 6 * p;
    r = '0;
    for (int j = 0; j < OW/2; j++) begin
      r[2*j+1] = pos[j];
      r[2*j]   = neg[j];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic prune(input int lim);
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].due > lim) exp_q.delete(i);
  endtask

  task automatic step(input logic rn, input logic fl, input logic [NREQ-1:0] r,
                      input logic [NREQ*WL-1:0] d);
    int idx;
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = rn;
    flush = fl;
    req = r;
    req_data = d;
    exp_gnt = '0;
    if (!rn) begin
      mptr = 0;
      prune(cyc - 1);
    end else if (fl) begin
      prune(cyc);
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (mptr + k) % NREQ;
        if (exp_gnt == '0 && r[idx]) begin
          exp_gnt[idx] = 1'b1;
          e.id = idx;
          e.data = ccm_model(d[idx*WL +: WL]);
          e.due = cyc + LAT;
          exp_q.push_back(e);
          mptr = (idx + 1) % NREQ;
        end
      end
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        if (!rst_n) begin
          chk("rst_resp_id", 32'(resp_id), 32'd0);
          chk("rst_resp_data", 32'(resp_data), 32'd0);
        end
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected: got resp_valid=1 id=%0d expected none (cycle %0d)", resp_id, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("resp_cycle", 32'(cyc), 32'(e.due));
            chk("resp_id", 32'(resp_id), 32'(e.id));
            chk("resp_data", 32'(resp_data), 32'(e.data));
          end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          e = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL resp_missing: got resp_valid=0 expected id=%0d (cycle %0d)", e.id, cyc);
        end
      end
    end
  end

  initial begin
    logic rn, fl;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b1111, 32'h11223344);
    step(1'b1, 1'b0, 4'b1111, 32'h0a0b0c0d);
    step(1'b1, 1'b0, 4'b0000, 32'h0);
    for (int i = 0; i < LAT; i++) step(1'b1, 1'b0, 4'b0000, 32'h0);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'b0100, 32'h005A0000);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'b1111, $urandom);
    step(1'b1, 1'b0, 4'b0100, $urandom);
    step(1'b1, 1'b0, 4'b1010, $urandom);
    step(1'b1, 1'b0, 4'b1010, $urandom);
    step(1'b1, 1'b0, 4'b0000, 32'h0);

    step(1'b1, 1'b0, 4'b0001, 32'h00000033);
    step(1'b1, 1'b1, 4'b1111, 32'h00000033);
    for (int i = 0; i < LAT + 1; i++) step(1'b1, 1'b0, 4'b0000, 32'h0);
    step(1'b1, 1'b0, 4'b1111, 32'h44332211);

`ifdef CCM_ARB_STATS_EN
    step(1'b1, 1'b1, 4'b0000, 32'h0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 4'b0010, $urandom);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'b1000, $urandom);
    step(1'b1, 1'b0, 4'b0000, 32'h0);
    chk("stat_gnt1", 32'(stat_gnt[1*16 +: 16]), 32'd10);
    chk("stat_gnt3", 32'(stat_gnt[3*16 +: 16]), 32'd6);
    chk("stat_gnt0", 32'(stat_gnt[0 +: 16]), 32'd0);
    chk("stat_busy", stat_busy, 32'd16);
`endif

    for (int i = 0; i < 400; i++) begin
      rn = ($urandom_range(0, 63) != 0);
      fl = ($urandom_range(0, 15) == 0);
      step(rn, fl, 4'($urandom), $urandom);
    end

    for (int i = 0; i < LAT + 2; i++) step(1'b1, 1'b0, 4'b0000, 32'h0);
    @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
